match_mac_accumulator: RTL
==========================

Name: match_mac_accumulator

Overview:
- Downstream consumer of the fast-prefix match stage in the TPPE sparse datapath.
- For each matched position emitted by the prefix stage (position plus fibre-B weight), it computes the fibre-A offset by prefix-counting a latched bitmask_a below that position. It then selects the fibre-A weight, multiplies the two weights and accumulates the product.
- At job end, signalled by processing_done returning high, it presents the dot-product result through a valid/ready handshake.

Parameters:
- BITMASK_WIDTH, 128, bitmask length; must match the prefix stage.
- WEIGHT_WIDTH, 8, unsigned weight width for fibres A and B.
- ACC_WIDTH, 32, accumulator width; must be >= 2*WEIGHT_WIDTH.
- Derived: PW = $clog2(BITMASK_WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job_start  in  1  one-cycle pulse, issued with the prefix stage's valid_match; latches fibre-A operands.
- bitmask_a  in  BITMASK_WIDTH  fibre-A occupancy bitmask.
- fibre_a_data_flat  in  BITMASK_WIDTH*WEIGHT_WIDTH  compressed fibre-A weights; entry i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- fast_valid  in  1  match strobe from the prefix stage.
- matched_position  in  PW  bit position of the match.
- matched_weight  in  WEIGHT_WIDTH  fibre-B weight for the match.
- processing_done  in  1  prefix-stage idle flag.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_data  out  ACC_WIDTH  accumulated sum of products.
- result_count  out  PW+1  number of matches accumulated.
- result_overflow  out  1  accumulator saturated during the job.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE.
  - busy, result_valid, result_overflow = 0; result_data, result_count = 0.
  - Pipeline valids, seen_busy flag and latched operands cleared.
  - Reset mid-job discards all partial state.
- FSM states: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - On job_start: latch bitmask_a and fibre_a_data_flat; clear accumulator, count, overflow and seen_busy; go to ACCUM.
  - fast_valid is ignored in IDLE.
- ACCUM:
  - Set seen_busy when processing_done==0.
  - When seen_busy==1 and processing_done==1, go to DRAIN.
  - A job with no matches (processing_done low for a single cycle) is legal and yields result 0, count 0.
- DRAIN:
  - Stay until both pipeline stage valids are 0, then go to OUTPUT and load result_data, result_count and result_overflow.
- OUTPUT:
  - result_valid=1; result_data, result_count and result_overflow are held stable.
  - On result_valid && result_ready: drop result_valid the next cycle and go to IDLE.
  - A same-cycle job_start is not accepted; job_start is ignored whenever busy=1.
- Pipeline (stage valids advance independently of state; new strobes are accepted only in ACCUM or DRAIN):
  - Stage 1, register on fast_valid:
    - a_off = popcount(bitmask_a_q & ((1<<matched_position)-1)), where position 0 gives 0.
    - Register a_w = fibre_a[a_off], b_w = matched_weight, and v1.
    - Whether bitmask_a_q[matched_position] is set is not checked; the upstream AND guarantees it.
  - Stage 2, when v1:
    - product = a_w*b_w (2*WEIGHT_WIDTH bits, unsigned), zero-extended to ACC_WIDTH.
    - acc <= acc + product, saturating at all-ones. Saturation sets sticky overflow.
    - count increments, saturating at 2^(PW+1)-1.
  - Latency: an accumulation is visible 2 cycles after its fast_valid cycle.
  - Back-to-back fast_valid, one per cycle, must be supported even though the prefix stage issues at most one every 3 cycles.
- result_data, result_count and result_overflow change only on entry to OUTPUT; they hold their values in IDLE until the next job's OUTPUT.

Test Plan:
- Setup for all scenarios: BITMASK_WIDTH=8, bitmask_a=8'b0000_1011, fibre_a[0..2]={2,3,5}.
- Two matches: job_start; fast_valid pos=3, w=7 (a_off=2, a_w=5) then pos=0, w=4 (a_w=2); processing_done falls then rises -> result_valid with result_data=43, count=2, overflow=0.
- Empty job: job_start; processing_done low for 1 cycle, then high; no fast_valid -> result_data=0, count=0, result_valid=1.
- Backpressure: hold result_ready=0 for 5 cycles in OUTPUT -> result_valid stays 1, data stable, busy=1, a job_start pulse is ignored. Then result_ready=1 -> result_valid=0 next cycle, state IDLE.
- Saturation: ACC_WIDTH=16, fibre_a all 255, bitmask_a=8'hFF; 8 matches with w=255 (each product 65025) -> result_data=16'hFFFF, overflow=1, count=8.
- Reset mid-job: assert rst_n=0 after one fast_valid in ACCUM -> all outputs 0 immediately. The next job (pos=1, w=3, a_w=3) yields result_data=9, count=1.
- Back-to-back strobes: fast_valid on 3 consecutive cycles, pos 0/1/3 with w=1 -> result_data=2+3+5=10, count=3.

Source files
------------

// File: rtl/match_mac_accumulator.sv
// match_mac_accumulator
//   Consumes matches from the fast-prefix stage. For every match it finds the
//   fibre-A offset by counting the latched bitmask_a bits below the matched
//   position, picks the fibre-A weight, multiplies it by the fibre-B weight and
//   accumulates with saturation. When the prefix stage goes idle again and the
//   pipeline is empty, the dot product is offered on a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   job_start             one-cycle pulse; latches fibre-A operands (IDLE only)
//   bitmask_a             fibre-A occupancy bitmask
//   fibre_a_data_flat     compressed fibre-A weights, entry i at [i*W +: W]
//   fast_valid            match strobe
//   matched_position      bit position of the match
//   matched_weight        fibre-B weight for the match
//   processing_done       prefix-stage idle flag
//   busy                  high whenever not IDLE
//   result_valid/ready    result handshake
//   result_data           saturated sum of products
//   result_count          number of matches accumulated (saturating)
//   result_overflow       accumulator saturated during the job
module match_mac_accumulator #(
  parameter  int BITMASK_WIDTH = 128,
  parameter  int WEIGHT_WIDTH  = 8,
  parameter  int ACC_WIDTH     = 32,
  localparam int PW            = $clog2(BITMASK_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  job_start,
  input  logic [BITMASK_WIDTH-1:0]              bitmask_a,
  input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] fibre_a_data_flat,
  input  logic                                  fast_valid,
  input  logic [PW-1:0]                         matched_position,
  input  logic [WEIGHT_WIDTH-1:0]               matched_weight,
  input  logic                                  processing_done,
  output logic                                  busy,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [ACC_WIDTH-1:0]                  result_data,
  output logic [PW:0]                           result_count,
  output logic                                  result_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_e;

  state_e state_q, state_d;

  logic [BITMASK_WIDTH-1:0]              bitmask_a_q;
  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] fibre_a_q;
  logic                                  seen_busy;

  // vld_pipe[1]: stage-1 operands valid; vld_pipe[2]: accumulation issued last cycle
  logic [2:1]              vld_pipe;
  logic                    accept;
  logic [WEIGHT_WIDTH-1:0] a_w_q, b_w_q;

  logic [ACC_WIDTH-1:0]    acc_q;
  logic [PW:0]             cnt_q;
  logic                    ovf_q;

  logic [BITMASK_WIDTH-1:0]  below;
  logic [PW-1:0]             a_off;
  logic [2*WEIGHT_WIDTH-1:0] prod;
  logic [ACC_WIDTH:0]        sum;

  // Strobes only count while a job is open or draining.
  assign accept = fast_valid && (state_q == ACCUM || state_q == DRAIN);

  // Offset into compressed fibre A = number of occupied slots below the match.
  always_comb begin
    below = bitmask_a_q & ~({BITMASK_WIDTH{1'b1}} << matched_position);
    a_off = '0;
    for (int i = 0; i < BITMASK_WIDTH; i++) a_off = a_off + PW'(below[i]);
  end

  assign prod = a_w_q * b_w_q;
  assign sum  = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(prod)};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_start) state_d = ACCUM;
      ACCUM:   if (seen_busy && processing_done) state_d = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_d = OUTPUT;
      OUTPUT:  if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy         = (state_q != IDLE);
    result_valid = (state_q == OUTPUT);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmask_a_q     <= '0;
      fibre_a_q       <= '0;
      seen_busy       <= 1'b0;
      vld_pipe        <= '0;
      a_w_q           <= '0;
      b_w_q           <= '0;
      acc_q           <= '0;
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      result_data     <= '0;
      result_count    <= '0;
      result_overflow <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], accept};

      if (accept) begin
        a_w_q <= fibre_a_q[a_off*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        b_w_q <= matched_weight;
      end

      // DRAIN guarantees the pipe is empty before IDLE, so a new job never
      // collides with an in-flight accumulation.
      if (state_q == IDLE && job_start) begin
        bitmask_a_q <= bitmask_a;
        fibre_a_q   <= fibre_a_data_flat;
        acc_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= 1'b0;
        seen_busy   <= 1'b0;
      end else begin
        if (vld_pipe[1]) begin
          if (sum[ACC_WIDTH]) begin
            acc_q <= '1;
            ovf_q <= 1'b1;
          end else begin
            acc_q <= sum[ACC_WIDTH-1:0];
          end
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        // Done is only trusted once the prefix stage has been seen busy.
        if (state_q == ACCUM && !processing_done) seen_busy <= 1'b1;
      end

      if (state_q == DRAIN && state_d == OUTPUT) begin
        result_data     <= acc_q;
        result_count    <= cnt_q;
        result_overflow <= ovf_q;
      end
    end
  end

endmodule
